// File: rtl/ind_pkg.sv
// Shared constants for the ALU result indicator: status codes, segment patterns
// and the conversion FSM states.
package ind_pkg;

    localparam logic [2:0] CTL_PLAIN = 3'd0;
    localparam logic [2:0] CTL_NEG   = 3'd1;
    localparam logic [2:0] CTL_DIV0  = 3'd2;
    localparam logic [2:0] CTL_FIX   = 3'd4;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_e;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_MINUS;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ind_scan_if.sv
// ALU-to-indicator bundle: result/status in, multiplexed 7-segment drive and busy out.
interface ind_scan_if;
    logic [7:0] ind_1_from_ALU;
    logic [2:0] control_from_ALU;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    modport master (
        output ind_1_from_ALU, control_from_ALU,
        input  seg, dp, an, busy
    );

    modport slave (
        input  ind_1_from_ALU, control_from_ALU,
        output seg, dp, an, busy
    );
endinterface

// File: rtl/ind_scan_bin2bcd_seq.sv
// Sequential double-dabble: start captures bin_i, 8 add-3/shift cycles, then one
// LOAD cycle with done_o high; start is ignored while busy_o is high.
module bin2bcd_seq
    import ind_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [7:0]  bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] bcd_o
);
    conv_state_e state_q, state_d;
    logic [19:0] sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;

    // Correct every BCD nibble that would overflow past 9 when doubled, then shift.
    function automatic logic [19:0] dabble(input logic [19:0] s);
        logic [11:0] b;
        b = s[19:8];
        for (int i = 0; i < 3; i++) begin
            if (b[4*i +: 4] >= 4'd5) b[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return {b, s[7:0]} << 1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SHIFT;
                    sr_d    = {12'd0, bin_i};
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                sr_d  = dabble(sr_q);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = LOAD;
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == LOAD);
        bcd_o  = sr_q[19:8];
    end

endmodule

// File: rtl/ind_scan.sv
// 4-digit common-anode indicator for the ALU result: snapshot, BCD conversion,
// status-dependent digit mapping and a prescaled digit scan with registered outputs.
module ind_scan
    import ind_pkg::*;
#(
    parameter int SCAN_DIV = 12500
) (
    input  logic      clk_IND,
    input  logic      rst_IND_n,
    ind_scan_if.slave io
);
    localparam int PW = $clog2(SCAN_DIV);

    logic [7:0]      snap_val_q;
    logic [2:0]      snap_ctl_q;
    logic            conv_start, conv_busy, conv_done;
    logic [11:0]     bcd;
    logic [3:0][6:0] disp_seg_q, map_seg;
    logic [3:0]      disp_dp_q, map_dp;
    logic [PW-1:0]   psc_q, psc_d;
    logic [1:0]      idx_q, idx_d;
    logic [6:0]      seg_q;
    logic            dp_q;
    logic [3:0]      an_q;
    logic [3:0]      h, t, u;

    // A new conversion is only started from idle; changes seen while busy are
    // picked up by this same comparison once the current conversion is done.
    assign conv_start = !conv_busy &&
        ({io.ind_1_from_ALU, io.control_from_ALU} != {snap_val_q, snap_ctl_q});

    bin2bcd_seq u_bin2bcd (
        .clk_i   (clk_IND),
        .rst_n_i (rst_IND_n),
        .start_i (conv_start),
        .bin_i   (io.ind_1_from_ALU),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    assign h = bcd[11:8];
    assign t = bcd[7:4];
    assign u = bcd[3:0];

    always_comb begin
        map_seg = {4{SEG_BLANK}};
        map_dp  = 4'hF;
        case (snap_ctl_q)
            CTL_PLAIN, CTL_NEG: begin
                map_seg[3] = (snap_ctl_q == CTL_NEG) ? SEG_MINUS : SEG_BLANK;
                map_seg[2] = (h == 4'd0) ? SEG_BLANK : seg_digit(h);
                map_seg[1] = (h == 4'd0 && t == 4'd0) ? SEG_BLANK : seg_digit(t);
                map_seg[0] = seg_digit(u);
            end
            CTL_DIV0: map_seg = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
            CTL_FIX: begin
                map_seg   = {SEG_BLANK, seg_digit(h), seg_digit(t), seg_digit(u)};
                map_dp[2] = 1'b0;
            end
            default: map_seg = {4{SEG_MINUS}};
        endcase
    end

    always_comb begin
        psc_d = psc_q + PW'(1);
        idx_d = idx_q;
        if (psc_q == PW'(SCAN_DIV - 1)) begin
            psc_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_IND) begin
        if (!rst_IND_n) begin
            snap_val_q <= '0;
            snap_ctl_q <= '0;
            disp_seg_q <= {4{SEG_BLANK}};
            disp_dp_q  <= 4'hF;
            psc_q      <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= 4'hF;
        end else begin
            if (conv_start) begin
                snap_val_q <= io.ind_1_from_ALU;
                snap_ctl_q <= io.control_from_ALU;
            end
            if (conv_done) begin
                disp_seg_q <= map_seg;
                disp_dp_q  <= map_dp;
            end
            psc_q <= psc_d;
            idx_q <= idx_d;
            // All three outputs are taken from the same slot in the same cycle.
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= disp_seg_q[idx_q];
            dp_q  <= disp_dp_q[idx_q];
        end
    end

    assign io.seg  = seg_q;
    assign io.dp   = dp_q;
    assign io.an   = an_q;
    assign io.busy = conv_busy;

endmodule

// File: doc/ind_scan.md
Name: ind_scan

Overview:
- Downstream stage of the calculator ALU.
- Consumes the 8-bit result and 3-bit status code and converts the result to BCD with a sequential double-dabble.
- Drives a 4-digit, multiplexed, common-anode 7-segment indicator.
- Renders plain, negative, division-error and fixed-point (x100) results.

Parameters:
- SCAN_DIV, 12500: clock cycles per digit slot (50 MHz / 4 kHz); legal range 2 or greater.

Ports:
- clk_IND  in  1  system clock; all logic on rising edge.
- rst_IND_n  in  1  reset, synchronous, active-low.
- ind_1_from_ALU  in  8  ALU result, unsigned.
- control_from_ALU  in  3  ALU status: 0 plain, 1 negative magnitude, 2 div-by-zero, 4 value x100.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  digit anodes, one-cold, active-low; an[0] is the rightmost digit.
- busy  out  1  high while a BCD conversion is in progress.

Behaviour:
- Reset (rst_IND_n=0 at a clock edge):
  - an=4'hF, seg=7'h7F, dp=1, busy=0.
  - Display registers cleared to blank; snapshot registers cleared to 0.
  - Scan index=0, prescaler=0, FSM=IDLE.
  - Reset mid-conversion aborts the conversion; nothing from it is loaded.
- Conversion FSM:
  - IDLE: if {ind_1_from_ALU, control_from_ALU} differs from the snapshot, latch both into the snapshot, set busy=1, go to SHIFT.
  - SHIFT: exactly 8 cycles of add-3-then-shift on a 12-bit BCD plus 8-bit binary register, then go to LOAD.
  - LOAD: one cycle. Write the four digit codes into the display registers, set busy=0, return to IDLE.
  - Input change to display-register update takes 10 cycles (capture, 8 shifts, load).
  - Inputs changing while busy are ignored. The IDLE comparison restarts conversion on the next cycle if the inputs still differ from the snapshot. Only the final stable value is guaranteed displayed.
  - First cycle after reset: inputs {0,0} equal the snapshot, so the display stays blank until a different input arrives.
- Digit mapping in LOAD (H/T/U = hundreds/tens/units BCD of the snapshot value):
  - Code 0: digit3 blank; digit2=H, blanked if H=0; digit1=T, blanked if H=0 and T=0; digit0=U always shown; no dp.
  - Code 1: digit3 shows minus; digits 2..0 as for code 0.
  - Code 2: digit3 'E', digit2 'r', digit1 'r', digit0 blank; the value is ignored.
  - Code 4: digit3 blank; digit2=H with its dp lit; digit1=T; digit0=U; no leading-zero blanking. Example: 7 shows as "0.07".
  - Any other code: all four digits show minus.
- Segment codes, active-low:
  - Digits 0–9: 40,79,24,30,19,12,02,78,00,10 hex.
  - E=06, r=2F, minus=3F, blank=7F.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1; at terminal count the scan index increments 0→1→2→3→0 (wraps).
  - an, seg and dp are registered and update on the cycle after the index changes; all three always come from the same digit slot.
  - A display-register update mid-slot is visible immediately in the current slot; there is no tearing within a cycle.
  - Scanning continues independently of conversion.
- Arithmetic: the BCD of 255 max fits in 12 bits; the add-3 correction is applied per nibble to any nibble ≥5 before each shift.

Decomposition:
- Shared package ind_pkg:
  - Status-code constants CTL_PLAIN=0, CTL_NEG=1, CTL_DIV0=2, CTL_FIX=4.
  - Segment-pattern constants (SEG_0..SEG_9, SEG_E, SEG_R, SEG_MINUS, SEG_BLANK).
  - FSM state typedef {IDLE, SHIFT, LOAD}.
- One sub-module: bin2bcd_seq.
  - Owns the start/busy/done handshake and the 8-cycle double-dabble.
  - Output is 12-bit BCD.
  - ind_scan keeps the snapshot, mapping, prescaler and scan mux.

Test Plan (SCAN_DIV=4):
- Reset: hold rst_IND_n=0 for 3 cycles → an=F, seg=7F, dp=1, busy=0. After release with inputs 0/0 → busy stays 0 and all slots are blank.
- ind=123, ctl=0 → busy high for 9 cycles, display updates at cycle 10. Slots 0..3 show seg 30, 24, 79, 7F, with an cycling E, D, B, 7.
- ind=5, ctl=1 → slot3=3F, slot2=7F, slot1=7F, slot0=12.
- ind=200, ctl=2 → slots 3..0 show 06, 2F, 2F, 7F.
- ind=250, ctl=4 → slot2=24 with dp=0, slot1=12, slot0=40, slot3=7F. Then ind=7, ctl=4 → slot2=40 with dp=0, slot1=40, slot0=78.
- Change ind 42→99 three cycles into a conversion → first conversion completes, a second starts the next cycle, final display shows "99".
- Separately, assert reset mid-SHIFT → outputs blank, busy=0.
